// File: rtl/counter_seq_pkg.sv
// Shared types and default sizes for the counter sequencer and its modulo counter.
package counter_seq_pkg;

  localparam int unsigned WIDTH_DEF   = 4;
  localparam int unsigned LOOPS_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/counter_sequencer_mod_counter.sv
// Modulo up-counter: clr beats en, at_term flags q reaching the terminal value.
module mod_counter
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] q,
  output logic             at_term
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign at_term = (q_q == term);

endmodule

// File: rtl/counter_sequencer.sv
// Run controller: sequences a modulo counter through start/pause/stop and
// completes after a latched number of wraps (0 = free-run until stop).
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned LOOPS_W = LOOPS_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic [WIDTH-1:0]   terminal,
  input  logic [LOOPS_W-1:0] loops,
  output logic [WIDTH-1:0]   q,
  output logic               wrap,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   term_q, term_d;
  logic [LOOPS_W-1:0] loops_q, loops_d;
  logic [LOOPS_W-1:0] loop_cnt_q, loop_cnt_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               cnt_en_c;
  logic               cnt_clr_c;
  logic               at_term_c;
  logic [LOOPS_W-1:0] loop_cnt_inc_c;
  logic               final_wrap_c;

  mod_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .en      (cnt_en_c),
    .clr     (cnt_clr_c),
    .term    (term_q),
    .q       (q),
    .at_term (at_term_c)
  );

  assign loop_cnt_inc_c = loop_cnt_q + LOOPS_W'(1);
  assign final_wrap_c   = (loops_q != '0) && (loop_cnt_inc_c == loops_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop beats pause beats counting
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !stop) state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = HOLD;
        end else if (at_term_c && final_wrap_c) begin
          state_d = DONE;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter controls, run bookkeeping and registered output values
  always_comb begin
    cnt_en_c   = 1'b0;
    cnt_clr_c  = 1'b0;
    term_d     = term_q;
    loops_d    = loops_q;
    loop_cnt_d = loop_cnt_q;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr_c = 1'b1;
        if (start && !stop) begin
          term_d     = terminal;
          loops_d    = loops;
          loop_cnt_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          cnt_clr_c  = 1'b1;
          loop_cnt_d = '0;
        end else if (!pause) begin
          if (at_term_c) begin
            cnt_clr_c  = 1'b1;
            wrap_d     = 1'b1;
            loop_cnt_d = loop_cnt_inc_c;
            done_d     = final_wrap_c;
          end else begin
            cnt_en_c = 1'b1;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          cnt_clr_c  = 1'b1;
          loop_cnt_d = '0;
        end
      end
      DONE:    cnt_clr_c = 1'b1;
      default: cnt_clr_c = 1'b1;
    endcase
    busy_d = (state_d == RUN) || (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      term_q     <= '0;
      loops_q    <= '0;
      loop_cnt_q <= '0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      term_q     <= term_d;
      loops_q    <= loops_d;
      loop_cnt_q <= loop_cnt_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign wrap = wrap_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed and random stimulus for counter_sequencer against a run-level reference model.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop  = 1'b0;
  logic [3:0] terminal = 4'd0;
  logic [3:0] loops    = 4'd0;
  logic [3:0] q;
  logic       wrap;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a run is active/held/finishing; counts tracked as integers
  bit m_active, m_held, m_finishing, m_wrap, m_done;
  int m_q, m_term, m_loops, m_wraps;

  counter_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .terminal (terminal),
    .loops    (loops),
    .q        (q),
    .wrap     (wrap),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_active = 0; m_held = 0; m_finishing = 0; m_wrap = 0; m_done = 0;
    m_q = 0; m_term = 0; m_loops = 0; m_wraps = 0;
  endfunction

  function automatic void model_edge(bit st, bit sp, bit pa, int t, int l);
    m_wrap = 0;
    m_done = 0;
    if (m_finishing) begin
      m_finishing = 0;
      m_q = 0;
    end else if (!m_active) begin
      m_q = 0;
      if (st && !sp) begin
        m_active = 1; m_held = 0; m_term = t; m_loops = l; m_wraps = 0;
      end
    end else if (sp) begin
      m_active = 0; m_held = 0; m_q = 0; m_wraps = 0;
    end else if (m_held) begin
      if (!pa) m_held = 0;
    end else if (pa) begin
      m_held = 1;
    end else if (m_q == m_term) begin
      m_q = 0;
      m_wrap = 1;
      m_wraps = (m_wraps + 1) % 16;
      if (m_loops != 0 && m_wraps == m_loops) begin
        m_active = 0; m_finishing = 1; m_done = 1;
      end
    end else begin
      m_q = m_q + 1;
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},    int'(q),    m_q);
    check({tag, ".wrap"}, int'(wrap), int'(m_wrap));
    check({tag, ".done"}, int'(done), int'(m_done));
    check({tag, ".busy"}, int'(busy), int'(m_active));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(start, stop, pause, int'(terminal), int'(loops));
    #1;
    check_all(tag);
  endtask

  task automatic run_until_q(input int target, input string tag);
    int budget = 40;
    while (m_q != target && budget > 0) begin
      step(tag);
      budget--;
    end
    check({tag, ".reach"}, int'(q), target);
  endtask

  initial begin
    int seq [0:8] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int wrap_cnt;
    reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    #1 check_all("reset_async");

    // Reset held while start toggles
    for (int i = 0; i < 3; i++) begin
      start = ~start;
      terminal = 4'd7;
      step("reset_hold");
    end
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step("idle_after_reset");

    // Basic run: terminal=3, loops=2
    terminal = 4'd3; loops = 4'd2; start = 1'b1;
    step("basic_start");
    start = 1'b0;
    check("basic_q0", int'(q), 0);
    for (int i = 1; i <= 8; i++) begin
      step("basic");
      check("basic_seq_q",  int'(q),    seq[i]);
      check("basic_seq_wrap", int'(wrap), int'(i == 4 || i == 8));
      check("basic_seq_done", int'(done), int'(i == 8));
    end
    check("basic_busy_done_cycle", int'(busy), 0);
    step("basic_after_done");
    check("basic_idle_q", int'(q), 0);

    // Pause at q=4 for 5 cycles, single loop
    terminal = 4'd9; loops = 4'd1; start = 1'b1;
    step("pause_start");
    start = 1'b0;
    run_until_q(4, "pause_to4");
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("pause_hold");
      check("pause_q_frozen", int'(q), 4);
      check("pause_busy", int'(busy), 1);
    end
    pause = 1'b0;
    step("pause_resume_edge");
    check("pause_resume_q", int'(q), 4);
    step("pause_resumed");
    check("pause_q5", int'(q), 5);
    run_until_q(0, "pause_to_wrap");
    check("pause_done", int'(done), 1);
    step("pause_done_exit");

    // Stop beats pause; start+stop in IDLE stays idle
    terminal = 4'd9; loops = 4'd0; start = 1'b1;
    step("stop_start");
    start = 1'b0;
    run_until_q(6, "stop_to6");
    stop = 1'b1; pause = 1'b1;
    step("stop_pause");
    check("stop_busy", int'(busy), 0);
    check("stop_q", int'(q), 0);
    pause = 1'b0; start = 1'b1;
    step("start_stop_idle");
    check("start_stop_busy", int'(busy), 0);
    stop = 1'b0; start = 1'b0;
    step("stop_clear");

    // terminal=0: wrap every cycle, done on the 3rd
    terminal = 4'd0; loops = 4'd3; start = 1'b1;
    step("t0_start");
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step("t0");
      check("t0_wrap", int'(wrap), 1);
      check("t0_done", int'(done), int'(i == 3));
    end
    step("t0_exit");

    // terminal=15, loops=0: free-run across loop counter rollover
    terminal = 4'd15; loops = 4'd0; start = 1'b1;
    step("free_start");
    start = 1'b0;
    wrap_cnt = 0;
    for (int i = 0; i < 16 * 18; i++) begin
      step("free");
      if (wrap) wrap_cnt++;
    end
    check("free_wraps", wrap_cnt, 18);
    check("free_busy", int'(busy), 1);
    stop = 1'b1;
    step("free_stop");
    stop = 1'b0;

    // Latched terminal ignores mid-run change
    terminal = 4'd5; loops = 4'd1; start = 1'b1;
    step("latch_start");
    start = 1'b0;
    step("latch_1");
    terminal = 4'd2; loops = 4'd0;
    run_until_q(5, "latch_to5");
    step("latch_wrap");
    check("latch_wrap_after5", int'(wrap), 1);
    check("latch_done", int'(done), 1);
    step("latch_exit");

    // Async reset mid-cycle at q=3
    terminal = 4'd9; loops = 4'd1; start = 1'b1;
    step("areset_start");
    start = 1'b0;
    run_until_q(3, "areset_to3");
    #3 reset = 1'b0;
    model_reset();
    #1;
    check_all("areset_now");
    step("areset_held");
    #2 reset = 1'b1;
    step("areset_release");

    // Randomized control traffic
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom % 4) == 0;
      stop     = ($urandom % 20) == 0;
      pause    = ($urandom % 6) == 0;
      terminal = 4'($urandom_range(0, 6));
      loops    = 4'($urandom_range(0, 3));
      if (($urandom % 150) == 0) begin
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("rand_areset");
        #1 reset = 1'b1;
      end
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run controller for the team's 4-bit up-counter datapath. It owns a modulo up-counter sub-module and sequences it through start / pause / stop / auto-complete. The counter wraps at a programmable terminal value for a programmable number of wraps, then signals done. The block sits between software-style control strobes and any logic that consumes the count value q.

Parameters:
WIDTH, 4, counter width; q and terminal are WIDTH bits.
LOOPS_W, 4, width of the wrap-count request and internal loop counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  begin a run; sampled only in IDLE.
pause  input  1  level; while 1 in RUN/HOLD, count is frozen.
stop  input  1  abort run; sampled in RUN/HOLD/IDLE.
terminal  input  WIDTH  last count value before wrap; latched at start.
loops  input  LOOPS_W  number of wraps per run; 0 = free-run until stop; latched at start.
q  output  WIDTH  current count.
wrap  output  1  one-cycle pulse, high in the cycle q returns to 0 after reaching terminal.
busy  output  1  high in RUN or HOLD.
done  output  1  one-cycle pulse on run completion.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, q=0, term_r=0, loops_r=0, loop_cnt=0, wrap=0, done=0, busy=0. Release is synchronous to the next clk edge.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, RUN, HOLD, DONE.
- IDLE:
  - start=1 and stop=0: latch terminal into term_r and loops into loops_r, set q=0 and loop_cnt=0, go to RUN.
  - start=1 and stop=1: stay in IDLE (stop wins).
  - q holds 0.
- RUN, per edge, with priority stop > pause > count:
  - stop=1: go to IDLE, q=0, loop_cnt=0.
  - Else pause=1: go to HOLD, q unchanged.
  - Else if q==term_r: q=0, wrap=1, loop_cnt=loop_cnt+1 (wraps modulo 2^LOOPS_W).
    - If loops_r!=0 and loop_cnt+1==loops_r: go to DONE, done=1.
  - Else: q=q+1.
- HOLD:
  - stop=1: go to IDLE, q=0.
  - Else pause=0: go to RUN. Counting resumes on the following edge, so there is 1 cycle of resume latency.
  - Otherwise hold all state.
- DONE: lasts exactly 1 cycle, q=0, then go to IDLE with done=0. A start asserted during DONE is ignored.
- wrap and done default to 0 every cycle unless set as above. On the final wrap, done and wrap are high in the same cycle.
- Latency: with start sampled at edge E0, q=0 after E0, q=1 after E1. One full period is term_r+1 cycles.
- term_r==0: q stays 0 and wrap pulses every RUN cycle.
- loops=0: never enters DONE; the run ends only via stop. loop_cnt wraps silently.
- Changes to terminal or loops mid-run have no effect; only the latched values are used.
- reset asserted mid-run: immediate return to reset values; no done pulse.

Decomposition:
- Package counter_seq_pkg:
  - state enum IDLE/RUN/HOLD/DONE, 2 bits;
  - default WIDTH and LOOPS_W constants.
- One sub-module, mod_counter:
  - inputs clk, reset, en, clr, term;
  - outputs q and at_term (q==term);
  - clr has priority over en.
- The sequencer FSM drives en/clr and owns loop_cnt, wrap and done.

Test Plan:
1. Reset: hold reset=0 for 3 cycles while toggling start -> q=0, busy=0, wrap=0, done=0; after release, IDLE is held with no count.
2. Basic run: terminal=3, loops=2, start pulse -> q sequence 0,1,2,3,0,1,2,3,0; wrap high at the two q=0 returns (cycles 4 and 8 after start); done=1 coincident with the 2nd wrap; busy falls after DONE; q=0.
3. Pause: terminal=9, loops=1; pause=1 for 5 cycles when q=4 -> q stays 4, busy=1; after pause=0, q reaches 5 one cycle after the resume edge; done is still reached at the 1st wrap.
4. Stop priority: in RUN with q=6, assert stop and pause together -> next cycle IDLE, q=0, busy=0, no wrap/done. In IDLE, start+stop together -> stays IDLE.
5. Corner values: terminal=0, loops=3 -> wrap high 3 consecutive cycles, done with the 3rd. terminal=15, loops=0 -> q wraps 15->0 indefinitely, done never asserts until stop.
6. Latch and async reset: change terminal from 5 to 2 mid-run -> wrap still occurs after q=5. Drive reset=0 mid-cycle at q=3 -> q=0 immediately without waiting for a clk edge; no done pulse.
